// File: rtl/pll_lock_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_lock_reset_seq
//
// Purpose
//   Sequences the rPLL LOCK/RESET pins and the active-low system reset.
//   After power-up the PLL is held in reset for PLL_RST_CYCLES, then the
//   sequencer waits for LOCK. The lock has to stay high for STABLE_CYCLES in a
//   row before the system reset is released. If the lock is lost while running,
//   the PLL and the system are reset again and the event is counted. If LOCK
//   does not appear within LOCK_TIMEOUT cycles, the PLL reset is retried.
//   The retry limit is unlimited.
//
//   This block runs on the 24 MHz crystal clock and never on the PLL output.
//   sys_rst_n goes to the PLL clock domain, where that domain's own reset
//   synchronizer consumes it.
//
// Ports
//   clk            in   1      24 MHz crystal clock
//   rst_n          in   1      asynchronous active-low reset
//   pll_lock       in   1      rPLL LOCK, asynchronous to clk (synchronized here)
//   sw_reset_req   in   1      one-cycle pulse, forces a full re-sequence
//   pll_reset      out  1      rPLL RESET, active high
//   sys_rst_n      out  1      system reset, active low
//   seq_state      out  2      current state (0 PLL_RST, 1 WAIT_LOCK,
//                              2 STABLE, 3 RUN)
//   lock_loss_cnt  out  CNT_W  saturating count of lock losses seen in RUN
//
// Build option
//   LOCK_LOSS_CNT_EN : when defined, the lock-loss counter is implemented.
//                      When undefined, lock_loss_cnt is tied to zero and
//                      there are no counter flops.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pll_lock_reset_seq #(
    parameter int PLL_RST_CYCLES = 24,
    parameter int LOCK_TIMEOUT   = 24000,
    parameter int STABLE_CYCLES  = 2400,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             sw_reset_req,
    output logic             pll_reset,
    output logic             sys_rst_n,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    // -------------------------------------------------------------------------
    // State encoding (visible on seq_state)
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_PLL_RST   = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    // One shared timer serves all three timed states. Its width must cover
    // the longest interval.
    localparam int MAX_AB    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ABC   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TIMER_W   = ($clog2(MAX_ABC) < 1) ? 1 : $clog2(MAX_ABC);

    localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

    localparam int SYNC_STAGES = 2;

    // -------------------------------------------------------------------------
    // pll_lock synchronizer. lock_sync lags pll_lock by two clk edges.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   lock_sync;

    assign sync_next = {sync_reg[SYNC_STAGES-2:0], pll_lock};
    assign lock_sync = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer state and timer
    // -------------------------------------------------------------------------
    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] timer_next;
    logic               pll_reset_reg;
    logic               pll_reset_next;
    logic               sys_rst_n_reg;
    logic               sys_rst_n_next;

    always_comb begin
        state_next = state_reg;

        if (sw_reset_req) begin
            // A software request overrides every other transition.
            state_next = ST_PLL_RST;
        end else begin
            case (state_reg)
                ST_PLL_RST: begin
                    if (timer_reg == PLL_RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_next = ST_STABLE;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        state_next = ST_PLL_RST;
                    end
                end
                ST_STABLE: begin
                    if (!lock_sync) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (timer_reg == STABLE_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin // ST_RUN
                    if (!lock_sync) begin
                        state_next = ST_PLL_RST;
                    end
                end
            endcase
        end
    end

    // The timer clears on every state change. It also clears on a software
    // request, so a request in PLL_RST restarts the reset pulse. The timer is
    // frozen in RUN, so it never wraps while the system is up.
    always_comb begin
        timer_next = timer_reg + 1'b1;
        if (sw_reset_req || (state_next != state_reg)) begin
            timer_next = '0;
        end else if (state_reg == ST_RUN) begin
            timer_next = timer_reg;
        end
    end

    // The outputs are decoded from the next state. This way they change on the
    // same edge as the state and are still driven directly from flops.
    always_comb begin
        pll_reset_next = (state_next == ST_PLL_RST);
        sys_rst_n_next = (state_next == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_PLL_RST;
            timer_reg     <= '0;
            pll_reset_reg <= 1'b1;
            sys_rst_n_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            pll_reset_reg <= pll_reset_next;
            sys_rst_n_reg <= sys_rst_n_next;
        end
    end

    assign seq_state = state_reg;
    assign pll_reset = pll_reset_reg;
    assign sys_rst_n = sys_rst_n_reg;

    // -------------------------------------------------------------------------
    // Lock-loss counter (optional)
    // -------------------------------------------------------------------------
`ifdef LOCK_LOSS_CNT_EN
    logic             lost_lock;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // A software request in the same cycle wins and is not a lock loss.
    assign lost_lock = (state_reg == ST_RUN) && !lock_sync && !sw_reset_req;

    always_comb begin
        cnt_next = cnt_reg;
        if (lost_lock && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign lock_loss_cnt = cnt_reg;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
`timescale 1ns/1ps

module tb_pll_lock_reset_seq;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int STABLE_CYCLES  = 8;
    localparam int CNT_W          = 8;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pll_lock;
    logic             sw_reset_req;
    logic             pll_reset;
    logic             sys_rst_n;
    logic [1:0]       seq_state;
    logic [CNT_W-1:0] lock_loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int losses   = 0;

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .sw_reset_req (sw_reset_req),
        .pll_reset    (pll_reset),
        .sys_rst_n    (sys_rst_n),
        .seq_state    (seq_state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    typedef struct {
        logic       lock;
        logic       sw;
        int         cycles;
        logic       exp_pr;
        logic       exp_srn;
        logic [1:0] exp_st;
        logic       loss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic lock, input logic sw, input int cycles,
                                input logic pr, input logic srn, input logic [1:0] st,
                                input logic loss);
        vec_t v;
        v.lock = lock; v.sw = sw; v.cycles = cycles;
        v.exp_pr = pr; v.exp_srn = srn; v.exp_st = st; v.loss = loss;
        return v;
    endfunction

    function automatic int exp_cnt();
`ifdef LOCK_LOSS_CNT_EN
        return (losses > CNT_MAX) ? CNT_MAX : losses;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic check_all(input string tag, input logic pr, input logic srn,
                             input logic [1:0] st);
        check({tag, " pll_reset"}, int'(pll_reset), int'(pr));
        check({tag, " sys_rst_n"}, int'(sys_rst_n), int'(srn));
        check({tag, " seq_state"}, int'(seq_state), int'(st));
        check({tag, " lock_loss_cnt"}, int'(lock_loss_cnt), exp_cnt());
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table of {pll_lock, sw_reset_req, cycles, pll_reset, sys_rst_n, state, loss}
        // Power-up with lock high
        vecs.push_back(mk(1, 0, 3, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0));   // edge 4
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd2, 0));   // edge 5
        vecs.push_back(mk(1, 0, 7, 0, 0, 2'd2, 0));   // edge 12
        vecs.push_back(mk(1, 0, 1, 0, 1, 2'd3, 0));   // edge 13
        vecs.push_back(mk(1, 0, 5, 0, 1, 2'd3, 0));
        // Software request in RUN, WAIT_LOCK, STABLE, PLL_RST
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 3, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 3, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd2, 0));
        vecs.push_back(mk(1, 0, 3, 0, 0, 2'd2, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 2, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 2'd0, 0));   // restarts the PLL reset timer
        vecs.push_back(mk(1, 0, 3, 1, 0, 2'd0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2'd2, 0));
        vecs.push_back(mk(1, 0, 7, 0, 0, 2'd2, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 2'd3, 0));
        // Lock loss in RUN, then lock stays low: timeout retries
        vecs.push_back(mk(0, 0, 2, 0, 1, 2'd3, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'd0, 1));   // 3 edges after drop
        vecs.push_back(mk(0, 0, 3, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd1, 0));
        vecs.push_back(mk(0, 0, 19, 0, 0, 2'd1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'd0, 0));   // timeout retry
        vecs.push_back(mk(0, 0, 3, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'd1, 0));
        vecs.push_back(mk(0, 0, 19, 0, 0, 2'd1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 2'd0, 0));

        rst_n = 1'b1; pll_lock = 1'b1; sw_reset_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b1, 1'b0, 2'd0);
        step(2);
        check_all("reset_held", 1'b1, 1'b0, 2'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            pll_lock = vecs[i].lock;
            if (vecs[i].sw) begin
                sw_reset_req = 1'b1;
                step(1);
                sw_reset_req = 1'b0;
                if (vecs[i].cycles > 1) step(vecs[i].cycles - 1);
            end else begin
                step(vecs[i].cycles);
            end
            if (vecs[i].loss) losses++;
            check_all($sformatf("vec%0d", i), vecs[i].exp_pr, vecs[i].exp_srn, vecs[i].exp_st);
        end

        // One-cycle lock glitch while in STABLE
        step(4);
        check_all("glitch_wait", 1'b0, 1'b0, 2'd1);
        pll_lock = 1'b1;
        step(2);
        check_all("glitch_still_wait", 1'b0, 1'b0, 2'd1);
        step(1);
        check_all("glitch_stable", 1'b0, 1'b0, 2'd2);
        step(3);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(1);
        check_all("glitch_pending", 1'b0, 1'b0, 2'd2);
        step(1);
        check_all("glitch_back_wait", 1'b0, 1'b0, 2'd1);
        step(1);
        check_all("glitch_restable", 1'b0, 1'b0, 2'd2);
        for (int k = 0; k < STABLE_CYCLES - 1; k++) begin
            step(1);
            check($sformatf("glitch_hold%0d sys_rst_n", k), int'(sys_rst_n), 0);
        end
        step(1);
        check_all("glitch_run", 1'b0, 1'b1, 2'd3);

        // Repeated lock losses up to saturation
        for (int i = 0; i < 300; i++) begin
            int k;
            pll_lock = 1'b0;
            step(3);
            losses++;
            if (i < 3 || (i >= 252 && i < 256) || i == 299)
                check_all($sformatf("loss%0d", i), 1'b1, 1'b0, 2'd0);
            pll_lock = 1'b1;
            k = 0;
            while (seq_state != 2'd3 && k < 40) begin
                step(1);
                k++;
            end
            if (seq_state != 2'd3) check($sformatf("relock%0d seq_state", i), int'(seq_state), 3);
        end
        check("saturated lock_loss_cnt", int'(lock_loss_cnt), exp_cnt());

        // Asynchronous reset in the middle of STABLE
        pll_lock = 1'b0;
        step(3);
        losses++;
        pll_lock = 1'b1;
        step(5);
        check_all("pre_rst_stable", 1'b0, 1'b0, 2'd2);
        step(2);
        #2 rst_n = 1'b0;
        losses = 0;
        #1;
        check_all("mid_rst", 1'b1, 1'b0, 2'd0);
        step(1);
        rst_n = 1'b1;
        step(3);
        check_all("post_rst_pllrst", 1'b1, 1'b0, 2'd0);
        step(1);
        check_all("post_rst_wait", 1'b0, 1'b0, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
